unidade_de_controle_multiciclo: RTL



---
 rtl/unidade_de_controle_multiciclo.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/unidade_de_controle_multiciclo.sv
// Multicycle phase sequencer for the iZero core: FETCH/DECODE/EXEC/MEM/WB with req/ack waits,
// fixed-priority masked interrupts at instruction boundaries, kernel/user mode and a sticky memory timeout.
module unidade_de_controle_multiciclo #(
    parameter int OP_W    = 6,
    parameter int FUNC_W  = 6,
    parameter int N_IRQ   = 4,
    parameter int TMO_W   = 8,
    parameter int TMO_MAX = 200,
    localparam int ID_W   = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   op,
    input  logic [FUNC_W-1:0] func,
    input  logic              im_ack,
    input  logic              mem_ack,
    input  logic              in_valid,
    input  logic [N_IRQ-1:0]  irq,
    input  logic [N_IRQ-1:0]  irq_mask,
    output logic              im_req,
    output logic              ir_write,
    output logic              pc_write,
    output logic              pc_vec,
    output logic              reg_write,
    output logic              mem_req,
    output logic              mem_we,
    output logic              inta,
    output logic [ID_W-1:0]   irq_id,
    output logic              user_mode,
    output logic              halted,
    output logic              fault,
    output logic [2:0]        phase
);
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
        S_WB = 3'd4, S_WAIT_IN = 3'd5, S_INTR = 3'd6, S_HALT = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CL_NOP, CL_ALU, CL_LOAD, CL_STORE, CL_IN, CL_JUMP, CL_HALT
    } cls_t;

    state_t           state, nxt;
    cls_t             cls, cls_dec;
    logic             ie;
    logic [TMO_W-1:0] cnt, cnt_nxt;
    logic [ID_W-1:0]  pri;
    logic             pend, done, fault_set, to_user, to_kernel;

    always_comb begin
        cls_dec = CL_NOP;
        if (op == '0)
            cls_dec = (func == FUNC_W'('h12)) ? CL_JUMP : CL_ALU;
        else if ((op >= OP_W'('h01) && op <= OP_W'('h0E)) || op == OP_W'('h10) || op == OP_W'('h11))
            cls_dec = CL_ALU;
        else if (op == OP_W'('h0F) || op == OP_W'('h16))
            cls_dec = CL_LOAD;
        else if (op == OP_W'('h12) || op == OP_W'('h17))
            cls_dec = CL_STORE;
        else if (op == OP_W'('h13))
            cls_dec = CL_IN;
        else if ((op >= OP_W'('h3C) && op <= OP_W'('h3E)) || op == OP_W'('h1F) ||
                 op == OP_W'('h20) || op == OP_W'('h21) || op == OP_W'('h15))
            cls_dec = CL_JUMP;
        else if (op == OP_W'('h3F))
            cls_dec = CL_HALT;
    end

    // Lowest-index enabled line wins.
    always_comb begin
        pri = '0;
        for (int i = N_IRQ - 1; i >= 0; i--)
            if (irq[i] && irq_mask[i]) pri = ID_W'(i);
    end

    assign pend   = ie && |(irq & irq_mask);
    assign phase  = state;
    assign halted = (state == S_HALT);

    always_comb begin
        nxt       = state;
        im_req    = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_vec    = 1'b0;
        reg_write = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        inta      = 1'b0;
        done      = 1'b0;
        fault_set = 1'b0;
        to_user   = 1'b0;
        to_kernel = 1'b0;
        cnt_nxt   = cnt;
        case (state)
            // Gated by rst so the fetch strobes drop the instant reset asserts.
            S_FETCH: begin
                im_req = rst;
                if (im_ack && rst) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    nxt      = S_DECODE;
                end
            end
            S_DECODE: nxt = (cls_dec == CL_HALT) ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (cls)
                    CL_ALU:            nxt = S_WB;
                    CL_LOAD, CL_STORE: nxt = S_MEM;
                    CL_IN:             nxt = S_WAIT_IN;
                    CL_JUMP: begin
                        pc_write  = 1'b1;
                        to_kernel = (op == OP_W'('h1F));
                        to_user   = (op == OP_W'('h20)) || (op == OP_W'('h21));
                        if (op == OP_W'('h3E)) nxt = S_WB;
                        else                   done = 1'b1;
                    end
                    default:           done = 1'b1;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (cls == CL_STORE);
                if (mem_ack) begin
                    cnt_nxt = '0;
                    if (cls == CL_LOAD) nxt = S_WB;
                    else                done = 1'b1;
                end else if (cnt == TMO_W'(TMO_MAX - 1)) begin
                    cnt_nxt   = '0;
                    fault_set = 1'b1;
                    nxt       = S_HALT;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_WAIT_IN: if (in_valid) nxt = S_WB;
            S_WB: begin
                reg_write = 1'b1;
                done      = 1'b1;
            end
            S_INTR: begin
                inta      = 1'b1;
                pc_write  = 1'b1;
                pc_vec    = 1'b1;
                to_kernel = 1'b1;
                nxt       = S_FETCH;
            end
            S_HALT:  nxt = S_HALT;
            default: nxt = S_FETCH;
        endcase
        if (done) nxt = pend ? S_INTR : S_FETCH;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_FETCH;
            cls       <= CL_NOP;
            ie        <= 1'b0;
            user_mode <= 1'b0;
            irq_id    <= '0;
            fault     <= 1'b0;
            cnt       <= '0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
            if (state == S_DECODE) cls <= cls_dec;
            if (fault_set) fault <= 1'b1;
            if (to_user) begin
                user_mode <= 1'b1;
                ie        <= 1'b1;
            end
            if (to_kernel) user_mode <= 1'b0;
            if (state == S_INTR) ie <= 1'b0;
            if (done && pend) irq_id <= pri;
        end
    end
endmodule
